// File: rtl/fetch_unit.sv
// fetch_unit: in-order instruction fetch with a two-deep credit window, redirect flushing and a decode buffer
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc_plus4
);
   typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
   state_t      state, state_next;
   logic [31:0] pc;
   logic [31:0] aq [2];
   logic        aq_head;
   logic [1:0]  outstanding, drop;
   logic [31:0] buf_pc [2];
   logic [31:0] buf_instr [2];
   logic        buf_head;
   logic [1:0]  buf_cnt;
   logic        has, pop, req_fire, rsp_fire, push;
   logic [1:0]  out_next, drop_next;
   // A same-cycle pop frees a slot, which keeps one request per cycle in steady state
   always_comb begin
      has = rst_n && buf_cnt != 2'd0;
      id_valid = has && !redirect_valid;
      pop = id_valid && id_ready;
      imem_req_valid = rst_n && state != IDLE && !redirect_valid &&
                       (3'(outstanding) + 3'(buf_cnt) - 3'(pop) < 3'd2);
      imem_addr = rst_n ? pc : RESET_PC;
      id_pc = has ? buf_pc[buf_head] : '0;
      id_instr = has ? buf_instr[buf_head] : '0;
      id_pc_plus4 = has ? buf_pc[buf_head] + 32'd4 : '0;
      req_fire = imem_req_valid && imem_req_ready;
      rsp_fire = imem_rsp_valid && outstanding != 2'd0;
      push = rsp_fire && drop == 2'd0 && !redirect_valid;
      out_next = outstanding + 2'(req_fire) - 2'(rsp_fire);
      drop_next = redirect_valid ? out_next : drop - 2'(rsp_fire && drop != 2'd0);
      state_next = state == IDLE ? FETCH : (drop_next != 2'd0 ? FLUSH : FETCH);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         pc <= RESET_PC;
         aq_head <= 1'b0;
         outstanding <= 2'd0;
         drop <= 2'd0;
         buf_head <= 1'b0;
         buf_cnt <= 2'd0;
      end else begin
         state <= state_next;
         outstanding <= out_next;
         drop <= drop_next;
         if (redirect_valid) pc <= redirect_pc & 32'hFFFF_FFFC;
         else if (req_fire) pc <= pc + 32'd4;
         if (rsp_fire) aq_head <= ~aq_head;
         if (redirect_valid) buf_cnt <= 2'd0;
         else begin
            if (pop) buf_head <= ~buf_head;
            buf_cnt <= buf_cnt + 2'(push) - 2'(pop);
         end
      end
   end
   // Storage arrays need no reset: occupancy counters qualify every read
   always_ff @(posedge clk) begin
      if (req_fire) aq[aq_head ^ outstanding[0]] <= pc;
      if (push) begin
         buf_pc[buf_head ^ buf_cnt[0]] <= aq[aq_head];
         buf_instr[buf_head ^ buf_cnt[0]] <= imem_rsp_data;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a one-cycle in-order instruction memory
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b1;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        id_valid;
   logic        id_ready = 1'b1;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;
   int checks = 0;
   int errors = 0;
   bit mem_en = 1'b1;
   logic [31:0] pend_a[$];
   logic [31:0] got_pc[$];
   logic [31:0] got_instr[$];

   fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
      .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
      .id_pc(id_pc), .id_pc_plus4(id_pc_plus4)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then present the next memory response
   task automatic tick();
      logic        fire;
      logic [31:0] a;
      @(negedge clk);
      fire = imem_req_valid && imem_req_ready;
      a = imem_addr;
      if (id_valid && id_ready) begin
         got_pc.push_back(id_pc);
         got_instr.push_back(id_instr);
      end
      @(posedge clk);
      #1;
      if (fire) pend_a.push_back(a);
      if (mem_en && pend_a.size() > 0) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data = f(pend_a.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data = '0;
      end
   endtask

   task automatic hold_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      mem_en = 1'b1;
      pend_a.delete();
      got_pc.delete();
      got_instr.delete();
      repeat (2) tick();
   endtask

   initial begin
      // Reset state and start-up fetch stream
      hold_reset();
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_id_instr", id_instr, 32'h0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_pc_plus4", id_pc_plus4, 32'h0);
      rst_n = 1'b1;
      #1;
      chk("idle_req_valid", imem_req_valid, 0);
      chk("idle_id_valid", id_valid, 0);
      tick();
      chk("c1_req_valid", imem_req_valid, 1);
      chk("c1_addr", imem_addr, 32'h0);
      tick();
      chk("c2_req_valid", imem_req_valid, 1);
      chk("c2_addr", imem_addr, 32'h4);
      chk("c2_id_valid", id_valid, 0);
      tick();
      chk("c3_req_valid", imem_req_valid, 1);
      chk("c3_addr", imem_addr, 32'h8);
      chk("c3_id_valid", id_valid, 1);
      chk("c3_id_pc", id_pc, 32'h0);
      chk("c3_id_instr", id_instr, f(32'h0));
      chk("c3_pc_plus4", id_pc_plus4, 32'h4);
      tick();
      chk("c4_id_pc", id_pc, 32'h4);
      tick();
      chk("c5_id_pc", id_pc, 32'h8);
      // Decode stall: buffer fills and the request stream stops
      id_ready = 1'b0;
      #1;
      chk("stall_req_valid", imem_req_valid, 0);
      repeat (4) begin
         tick();
         chk("stall_req_valid", imem_req_valid, 0);
         chk("stall_id_valid", id_valid, 1);
         chk("stall_id_pc", id_pc, 32'h8);
         chk("stall_id_instr", id_instr, f(32'h8));
      end
      tick();
      id_ready = 1'b1;
      #1;
      chk("unstall_req_valid", imem_req_valid, 1);
      chk("unstall_addr", imem_addr, 32'h10);
      chk("unstall_id_pc", id_pc, 32'h8);
      repeat (6) tick();
      chk("steady_id_pc", id_pc, 32'h20);
      chk("steady_addr", imem_addr, 32'h28);
      chk("handoff_count", got_pc.size(), 8);
      for (int i = 0; i < got_pc.size(); i++) begin
         chk("handoff_pc", got_pc[i], 32'(4 * i));
         chk("handoff_instr", got_instr[i], f(32'(4 * i)));
      end
      // Redirect with two requests outstanding
      hold_reset();
      mem_en = 1'b0;
      rst_n = 1'b1;
      tick();
      chk("b_c1_addr", imem_addr, 32'h0);
      tick();
      chk("b_c2_addr", imem_addr, 32'h4);
      tick();
      chk("b_credit_full", imem_req_valid, 0);
      mem_en = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0103;
      #1;
      chk("b_redir_req_valid", imem_req_valid, 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("b_flush_req_valid", imem_req_valid, 0);
      chk("b_flush_addr", imem_addr, 32'h100);
      tick();
      chk("b_new_req_valid", imem_req_valid, 1);
      chk("b_new_addr", imem_addr, 32'h100);
      chk("b_stale_dropped", id_valid, 0);
      tick();
      chk("b_c6_addr", imem_addr, 32'h104);
      chk("b_c6_id_valid", id_valid, 0);
      tick();
      chk("b_first_id_valid", id_valid, 1);
      chk("b_first_id_pc", id_pc, 32'h100);
      chk("b_first_id_instr", id_instr, f(32'h100));
      // Redirect colliding with a response while decode holds a valid instruction
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      #1;
      chk("c_redir_id_valid", id_valid, 0);
      chk("c_redir_req_valid", imem_req_valid, 0);
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("c_req_valid", imem_req_valid, 1);
      chk("c_addr", imem_addr, 32'h200);
      chk("c_rsp_discarded", id_valid, 0);
      tick();
      chk("c_c9_addr", imem_addr, 32'h204);
      chk("c_c9_id_valid", id_valid, 0);
      tick();
      chk("c_id_pc", id_pc, 32'h200);
      chk("c_no_pop", got_pc.size(), 0);
      // Address wrap at the top of the address space
      redirect_valid = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      #1;
      chk("d_addr_top", imem_addr, 32'hFFFF_FFFC);
      tick();
      chk("d_addr_wrap", imem_addr, 32'h0);
      tick();
      chk("d_id_pc_top", id_pc, 32'hFFFF_FFFC);
      chk("d_plus4_wrap", id_pc_plus4, 32'h0);
      chk("d_instr_top", id_instr, f(32'hFFFF_FFFC));
      tick();
      chk("d_id_pc_zero", id_pc, 32'h0);
      chk("d_plus4_zero", id_pc_plus4, 32'h4);
      // Reset while flushing two stale requests
      hold_reset();
      mem_en = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0040;
      tick();
      redirect_valid = 1'b0;
      rst_n = 1'b0;
      mem_en = 1'b1;
      #1;
      chk("e_rst_req_valid", imem_req_valid, 0);
      chk("e_rst_addr", imem_addr, 32'h0);
      tick();
      rst_n = 1'b1;
      #1;
      chk("e_idle_req_valid", imem_req_valid, 0);
      chk("e_idle_id_valid", id_valid, 0);
      chk("e_idle_id_instr", id_instr, 32'h0);
      chk("e_idle_id_pc", id_pc, 32'h0);
      chk("e_idle_pc_plus4", id_pc_plus4, 32'h0);
      tick();
      chk("e_c1_req_valid", imem_req_valid, 1);
      chk("e_c1_addr", imem_addr, 32'h0);
      tick();
      chk("e_c2_addr", imem_addr, 32'h4);
      chk("e_stale_ignored", id_valid, 0);
      tick();
      chk("e_id_valid", id_valid, 1);
      chk("e_id_pc", id_pc, 32'h0);
      chk("e_id_instr", id_instr, f(32'h0));
      tick();
      chk("e_id_pc_next", id_pc, 32'h4);
      chk("e_id_instr_next", id_instr, f(32'h4));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
